alu_div_ctrl: RTL and testbench

- Sequential unsigned 32-bit restoring divider controller.
- Owns one ALU32b instance and drives it with op=110 (sub) every iteration. Uses the ALU result and lt flag to build quotient and remainder one bit per cycle.
- Sits beside the ALU in the datapath as the first multi-cycle arithmetic unit; a start/done handshake exposes it to the surrounding control.

---
 rtl/alu_div_ctrl_pkg.sv | 32 +++
 rtl/alu_div_ctrl_if.sv | 32 +++
 rtl/ALU32b.sv | 36 +++
 rtl/alu_div_ctrl.sv | 166 ++++++++++++++++
 tb/tb_alu_div_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_div_ctrl_pkg
// Description : Shared constants and types for the sequential divider
//               controller: ALU opcode encodings, operand width, iteration
//               count and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_div_ctrl_pkg;

    // Operand width, fixed by ALU32b.
    localparam int WIDTH  = 32;
    // One quotient bit per iteration.
    localparam int N_ITER = WIDTH;
    localparam int CNT_W  = $clog2(N_ITER);

    // ALU32b opcodes.
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_ITER  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage : alu_div_ctrl_pkg
`default_nettype wire

// File: rtl/alu_div_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_div_ctrl_if
// Description : Start/done handshake and operand/result bus of the divider.
//               master : requester (drives start and operands)
//               slave  : divider   (drives busy, done and results)
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_div_ctrl_if;
    import alu_div_ctrl_pkg::*;

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface : alu_div_ctrl_if
`default_nettype wire

// File: rtl/ALU32b.sv
`default_nettype none
// ============================================================================
// Module      : ALU32b
// Description : 32-bit combinational ALU.
//               a, b   : operands
//               op     : opcode (AND/OR/ADD/XOR/SUB)
//               result : operation result (mod 2^32)
//               lt     : unsigned a < b
// Revision    : 1.0 - initial release
// ============================================================================
module ALU32b
    import alu_div_ctrl_pkg::*;
(
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    input  wire logic [2:0]       op,
    output logic      [WIDTH-1:0] result,
    output logic                  lt
);

    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = a + b;
            OP_XOR:  result = a ^ b;
            OP_SUB:  result = a - b;
            default: result = '0;
        endcase
    end

    assign lt = (a < b);

endmodule : ALU32b
`default_nettype wire

// File: rtl/alu_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_div_ctrl
// Description : Sequential unsigned 32-bit restoring divider. Drives one
//               ALU32b with trial subtractions, one quotient bit per cycle.
//               clk   : system clock, rising edge
//               reset : asynchronous active-high reset
//               bus   : start/operands in, busy/done/results out (slave)
//               Optional macro DIV_SHORTCUT_EN: CHECK finishes immediately
//               when dividend < divisor or dividend == divisor.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_div_ctrl
    import alu_div_ctrl_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     reset,
    alu_div_ctrl_if.slave bus
);

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   dividend_q,  dividend_d;
    logic [WIDTH-1:0]   divisor_q,   divisor_d;
    logic [WIDTH-1:0]   rem_q,       rem_d;
    logic [WIDTH-1:0]   quo_q,       quo_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIDTH-1:0]   quotient_q,  quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q,       dbz_d;

    logic [WIDTH-1:0]   w_alu_a;
    logic [WIDTH-1:0]   w_alu_b;
    logic [2:0]         w_alu_op;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_lt;
    logic [WIDTH:0]     w_shift;
    logic               w_take;

    ALU32b u_alu (
        .a      (w_alu_a),
        .b      (w_alu_b),
        .op     (w_alu_op),
        .result (w_alu_res),
        .lt     (w_alu_lt)
    );

    // Partial remainder shifted left with the next dividend bit appended.
    assign w_shift = {rem_q, quo_q[WIDTH-1]};
    // A carried-out bit means S >= 2^32 > divisor, so subtraction always fits.
    assign w_take  = w_shift[WIDTH] | ~w_alu_lt;

    // ALU operand mux kept apart from the FSM so the flags never feed back
    // into their own select logic.
    always_comb begin
        w_alu_a  = '0;
        w_alu_b  = '0;
        w_alu_op = 3'b000;
        if (state_q == S_ITER) begin
            w_alu_a  = w_shift[WIDTH-1:0];
            w_alu_b  = divisor_q;
            w_alu_op = OP_SUB;
        end
`ifdef DIV_SHORTCUT_EN
        else if (state_q == S_CHECK) begin
            w_alu_a  = dividend_q;
            w_alu_b  = divisor_q;
            w_alu_op = OP_SUB;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dividend_d = bus.dividend;
                    divisor_d  = bus.divisor;
                    dbz_d      = 1'b0;
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                if (divisor_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = dividend_q;
                    dbz_d       = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    rem_d   = '0;
                    quo_d   = dividend_q;
                    cnt_d   = '0;
                    state_d = S_ITER;
`ifdef DIV_SHORTCUT_EN
                    if (w_alu_lt) begin
                        quotient_d  = '0;
                        remainder_d = dividend_q;
                        state_d     = S_DONE;
                    end else if (w_alu_res == '0) begin
                        quotient_d  = {{(WIDTH-1){1'b0}}, 1'b1};
                        remainder_d = '0;
                        state_d     = S_DONE;
                    end
`endif
                end
            end
            S_ITER: begin
                rem_d = w_take ? w_alu_res : w_shift[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], w_take};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N_ITER - 1)) begin
                    quotient_d  = {quo_q[WIDTH-2:0], w_take};
                    remainder_d = w_take ? w_alu_res : w_shift[WIDTH-1:0];
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            dividend_q  <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == S_CHECK) || (state_q == S_ITER);
    assign bus.done        = (state_q == S_DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule : alu_div_ctrl
`default_nettype wire

// File: tb/tb_alu_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_div_ctrl
// Description : Self-checking bench for alu_div_ctrl. Directed and random
//               divisions compared against plain arithmetic division;
//               handshake, ignored-start and mid-operation reset scenarios.
//               Honours DIV_SHORTCUT_EN for expected latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_div_ctrl;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    alu_div_ctrl_if bus ();

    alu_div_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: division from arithmetic, latency from the timing rules.
    function automatic void ref_div(input logic [31:0] dvd, input logic [31:0] dvs,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic z, output int lat);
        if (dvs == 32'd0) begin
            q = 32'hFFFF_FFFF; r = dvd; z = 1'b1; lat = 2;
        end else begin
            q = dvd / dvs; r = dvd % dvs; z = 1'b0;
`ifdef DIV_SHORTCUT_EN
            lat = (dvd <= dvs) ? 2 : 34;
`else
            lat = 34;
`endif
        end
    endfunction

    // Issue one start and wait (bounded) for done; operands are scrambled
    // after the start edge to show capture isolation.
    task automatic run_div(input logic [31:0] dvd, input logic [31:0] dvs,
                           output int lat, output int bcnt, output bit to);
        bus.dividend = dvd;
        bus.divisor  = dvs;
        bus.start    = 1'b1;
        lat  = 0;
        bcnt = 0;
        do begin
            @(posedge clk); #1;
            bus.start    = 1'b0;
            bus.dividend = $urandom;
            bus.divisor  = $urandom;
            lat++;
            if (bus.busy) bcnt++;
        end while (!bus.done && lat < 100);
        to = !bus.done;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.done, bus.div_by_zero});
        end
        checks++;
        if (bus.quotient !== 32'd0) begin
            errors++; $display("FAIL reset_quotient: got %h expected 0", bus.quotient);
        end
        checks++;
        if (bus.remainder !== 32'd0) begin
            errors++; $display("FAIL reset_remainder: got %h expected 0", bus.remainder);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [31:0] dvd_t [10];
        logic [31:0] dvs_t [10];
        logic [31:0] eq, er;
        logic        ez;
        int          el, lat, bcnt;
        bit          to;
        dvd_t = '{32'd100, 32'hFFFF_FFFF, 32'd5, 32'd9, 32'd3, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'hDEAD_BEEF};
        dvs_t = '{32'd7,   32'h8000_0000, 32'd0, 32'd3, 32'd9, 32'd9, 32'd1, 32'd1,         32'hFFFF_FFFF, 32'd2};
        for (int i = 0; i < 10; i++) begin
            ref_div(dvd_t[i], dvs_t[i], eq, er, ez, el);
            run_div(dvd_t[i], dvs_t[i], lat, bcnt, to);
            checks++;
            if (to) begin
                errors++; $display("FAIL dir%0d_timeout: no done after %0d cycles, required %0d", i, lat, el);
                continue;
            end
            checks++;
            if (lat != el) begin
                errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, el);
            end
            checks++;
            if (bcnt != el - 1) begin
                errors++; $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, bcnt, el - 1);
            end
            checks++;
            if (bus.quotient !== eq) begin
                errors++; $display("FAIL dir%0d_quotient: got %h expected %h", i, bus.quotient, eq);
            end
            checks++;
            if (bus.remainder !== er) begin
                errors++; $display("FAIL dir%0d_remainder: got %h expected %h", i, bus.remainder, er);
            end
            checks++;
            if (bus.div_by_zero !== ez) begin
                errors++; $display("FAIL dir%0d_div_by_zero: got %b expected %b", i, bus.div_by_zero, ez);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++; $display("FAIL dir%0d_done_pulse: got done=%b busy=%b expected 0 0", i, bus.done, bus.busy);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] dvd, dvs, eq, er;
        logic        ez;
        int          el, lat, bcnt;
        bit          to;
        for (int i = 0; i < 24; i++) begin
            dvd = $urandom;
            case ($urandom_range(0, 4))
                0: dvs = $urandom_range(1, 255);
                1: dvs = $urandom;
                2: dvs = dvd >> $urandom_range(0, 31);
                3: dvs = dvd;
                default: dvs = 32'd0;
            endcase
            ref_div(dvd, dvs, eq, er, ez, el);
            run_div(dvd, dvs, lat, bcnt, to);
            checks++;
            if (to) begin
                errors++; $display("FAIL rnd%0d_timeout: no done after %0d cycles, required %0d", i, lat, el);
                continue;
            end
            checks++;
            if (lat != el) begin
                errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, el);
            end
            checks++;
            if (bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== ez) begin
                errors++;
                $display("FAIL rnd%0d_result %h/%h: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                         i, dvd, dvs, bus.quotient, bus.remainder, bus.div_by_zero, eq, er, ez);
            end
            @(posedge clk); #1;
        end
    endtask

    // 1000/10 in flight; starts during ITER and during DONE must be dropped.
    task automatic test_start_ignored;
        int          dones = 0;
        int          first = 0;
        logic [31:0] qs = '0, rs = '0;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd10;
        bus.start    = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            bus.start = (c == 5) || (c == 34);
            if (c == 5 || c == 34) begin
                bus.dividend = 32'd7;
                bus.divisor  = 32'd7;
            end
            if (bus.done) begin
                dones++;
                if (first == 0) begin
                    first = c; qs = bus.quotient; rs = bus.remainder;
                end
            end
        end
        checks++;
        if (dones != 1) begin
            errors++; $display("FAIL ignore_done_count: got %0d expected 1", dones);
        end
        checks++;
        if (first != 34) begin
            errors++; $display("FAIL ignore_latency: got %0d expected 34", first);
        end
        checks++;
        if (qs !== 32'd100 || rs !== 32'd0) begin
            errors++; $display("FAIL ignore_result: got q=%0d r=%0d expected q=100 r=0", qs, rs);
        end
    endtask

    task automatic test_reset_mid;
        int          dones = 0;
        int          lat, bcnt;
        bit          to;
        bus.dividend = 32'd123456;
        bus.divisor  = 32'd321;
        bus.start    = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 ||
            bus.quotient !== 32'd0 || bus.remainder !== 32'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got busy=%b done=%b z=%b q=%h r=%h expected all 0",
                     bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++; $display("FAIL midreset_no_done: got %0d active cycles expected 0", dones);
        end
        run_div(32'd50, 32'd8, lat, bcnt, to);
        checks++;
        if (to || lat != 34) begin
            errors++; $display("FAIL midreset_fresh_latency: got %0d (timeout=%0b) expected 34", lat, to);
        end
        checks++;
        if (bus.quotient !== 32'd6 || bus.remainder !== 32'd2) begin
            errors++; $display("FAIL midreset_fresh_result: got q=%0d r=%0d expected q=6 r=2", bus.quotient, bus.remainder);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_start_ignored;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_div_ctrl
`default_nettype wire
